mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Memory-stage load/store sequencer placed directly upstream of the 64x16 data memory.
//  Accepts one load or store at a time from the execute stage over a valid/ready handshake.
//  Drives the memory's level-sensitive addr/din/wea so that addr and din are stable
//  before wea rises and are held until wea has fallen.
//  Returns load data, tagged with its destination register, to writeback over valid/ready.
// PARAMETERS
//  DATA_W     16  data word width
//  ADDR_W     16  address width
//  MEM_DEPTH  64  number of implemented words (valid addresses 0..MEM_DEPTH-1)
//  RD_W       3   destination-register tag width
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       reset, synchronous, active-low
//  req_valid  in   1       execute stage presents a request
//  req_ready  out  1       unit can accept a request this cycle
//  req_we     in   1       1 = store, 0 = load
//  req_addr   in   ADDR_W  word address
//  req_wdata  in   DATA_W  store data
//  req_rd     in   RD_W    load destination tag
//  mem_addr   out  ADDR_W  to data memory addr
//  mem_din    out  DATA_W  to data memory din
//  mem_wea    out  1       to data memory wea
//  mem_dout   in   DATA_W  from data memory dout, combinational
//  rsp_valid  out  1       load result available
//  rsp_ready  in   1       writeback stage takes the result
//  rsp_data   out  DATA_W  load data
//  rsp_rd     out  RD_W    load destination tag
//  rsp_err    out  1       out-of-range access flag (see CONFIGURATION)
// BEHAVIOUR
//  - One clock domain. Reset is synchronous and active-low.
//  - Reset values: state IDLE; mem_addr=0, mem_din=0, mem_wea=0, rsp_valid=0,
//    rsp_data=0, rsp_rd=0, rsp_err=0. req_ready=0 while rst_n=0.
//  - All mem_* and rsp_* outputs are registered. req_ready = (state==IDLE) & rst_n.
//  - A request is accepted on an edge where req_valid & req_ready; all req_* fields are
//    captured on that edge.
//  - FSM states: IDLE, ST_SETUP, ST_WRITE, LD_READ, LD_RESP.
//  - Transitions:
//    IDLE   -> ST_SETUP on an accepted store; mem_addr/mem_din loaded, mem_wea stays 0.
//    IDLE   -> LD_READ on an accepted load; mem_addr loaded, mem_wea stays 0.
//    ST_SETUP -> ST_WRITE; mem_wea<=1.
//    ST_WRITE -> IDLE; mem_wea<=0. mem_addr/mem_din are held until the next accept.
//    LD_READ  -> LD_RESP; rsp_data<=mem_dout, rsp_rd<=tag, rsp_valid<=1.
//    LD_RESP  -> IDLE on rsp_valid & rsp_ready; rsp_valid<=0. rsp_data/rsp_rd are held.
//  - Timing: a store holds wea high for exactly 1 cycle; the unit is busy for 2 cycles
//    after accept. A load's rsp_valid rises 2 cycles after accept.
//  - Throughput: 1 store per 3 cycles.
//  - Back-pressure: in LD_RESP, rsp_valid and its data stay stable and no new request is
//    accepted until rsp_ready.
//  - Invariant: mem_addr and mem_din never change in a cycle where mem_wea=1 or where
//    mem_wea will rise next cycle.
//  - Address arithmetic: no translation; the full ADDR_W value is passed through.
//  - Reset mid-operation: the FSM returns to IDLE and mem_wea=0 on that edge.
//    A store in ST_SETUP is dropped.
//    A store in ST_WRITE may already have written; this is accepted behaviour.
//    A pending load response is discarded.
//  - A request arriving while req_ready=0 is ignored; the requester must hold it.
// CONFIGURATION
//  Macro MEM_BOUNDS_CHECK_EN:
//   defined: any req_addr >= MEM_DEPTH is out of range.
//     Out-of-range store: walks ST_SETUP/ST_WRITE with mem_wea held 0; no response.
//     Out-of-range load: skips the read and returns rsp_data=0 with rsp_err=1.
//     rsp_err is cleared on the next in-range load response.
//   undefined: no range check; rsp_err is tied 0 and all addresses go to memory unchanged.
// STRUCTURE
//  - Shared package risc_pkg holds DATA_W/ADDR_W/RD_W constants, MEM_DEPTH, and the
//    mau_state_t enum (IDLE, ST_SETUP, ST_WRITE, LD_READ, LD_RESP).
//  - One sub-module is natural: mau_range_check (combinational in-range compare),
//    instantiated only under MEM_BOUNDS_CHECK_EN.
//  - FSM, capture registers and handshakes live in the top module.
// TESTING (bench includes a behavioural 64x16 level-sensitive memory model)
//  1. Reset: hold rst_n=0 for 3 cycles -> all outputs 0 and req_ready=0;
//     release -> req_ready=1 on the next cycle.
//  2. Store 0xBEEF to addr 5, then load addr 5 tag 3 ->
//     wea high for exactly 1 cycle with addr=5 stable from 1 cycle before to 1 cycle after;
//     rsp_valid 2 cycles after the load accept with rsp_data=0xBEEF, rsp_rd=3.
//  3. Back-pressure: load addr 5 with rsp_ready=0 for 4 cycles ->
//     rsp_valid held with data stable and req_ready=0; rsp_ready=1 -> IDLE next cycle.
//  4. Back-to-back: 64 stores of data=addr^0xA5A5 to addr 0..63, then 64 loads ->
//     every rsp_data matches; store spacing is 3 cycles.
//  5. Reset mid-op: assert rst_n=0 in ST_SETUP of a store 0x1234 to addr 9 ->
//     mem[9] is unchanged and the FSM is IDLE after release.
//  6. MEM_BOUNDS_CHECK_EN: store 0x5555 to addr 64 -> wea never rises;
//     load addr 70 -> rsp_data=0, rsp_err=1. Without the macro, rsp_err is always 0.

Source files
------------

// File: rtl/risc_pkg.sv
// ----------------------------------------------------------------------------
// risc_pkg
// Shared constants and types for the memory-stage load/store sequencer.
//   DATA_W     data word width
//   ADDR_W     word address width
//   MEM_DEPTH  number of implemented data-memory words (0..MEM_DEPTH-1)
//   RD_W       destination-register tag width
//   mau_state_t  sequencer FSM states
//   addr_in_range()  1 when an address hits an implemented word
// ----------------------------------------------------------------------------
package risc_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 16;
    localparam int MEM_DEPTH = 64;
    localparam int RD_W      = 3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ST_SETUP = 3'd1,
        ST_WRITE = 3'd2,
        LD_READ  = 3'd3,
        LD_RESP  = 3'd4
    } mau_state_t;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return addr < ADDR_W'(MEM_DEPTH);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// ----------------------------------------------------------------------------
// mem_access_unit_if
// Bundles the three buses around the load/store sequencer:
//   req_*  execute stage -> unit  (valid/ready)
//   mem_*  unit <-> data memory   (level-sensitive addr/din/wea, comb dout)
//   rsp_*  unit -> writeback      (valid/ready)
// Handshake rule for req and rsp: a transfer happens on a rising clk edge where
// valid & ready are both 1; the sender holds valid and its payload stable until
// that edge, and ready may be asserted independently of valid.
// Modports:
//   slave  - the sequencer itself
//   master - the surrounding pipeline / memory environment
// ----------------------------------------------------------------------------
interface mem_access_unit_if;
    import risc_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [RD_W-1:0]   req_rd;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_wea;
    logic [DATA_W-1:0] mem_dout;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [RD_W-1:0]   rsp_rd;
    logic              rsp_err;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_rd,
        input  mem_dout, rsp_ready,
        output req_ready,
        output mem_addr, mem_din, mem_wea,
        output rsp_valid, rsp_data, rsp_rd, rsp_err
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_rd,
        output mem_dout, rsp_ready,
        input  req_ready,
        input  mem_addr, mem_din, mem_wea,
        input  rsp_valid, rsp_data, rsp_rd, rsp_err
    );

endinterface

// File: rtl/mau_range_check.sv
// ----------------------------------------------------------------------------
// mau_range_check
// Combinational compare: in_range = (addr < MEM_DEPTH).
// Ports:
//   addr      in   ADDR_W  request word address
//   in_range  out  1       address hits an implemented memory word
// ----------------------------------------------------------------------------
module mau_range_check
    import risc_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    output logic              in_range
);

    assign in_range = addr_in_range(addr);

endmodule

// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
// Memory-stage load/store sequencer in front of the 64x16 data memory.
// Takes one load or store at a time, sequences the memory's level-sensitive
// write enable so addr/din settle a cycle before wea rises and stay put until
// the next request is accepted, and returns tagged load data to writeback.
//
// Ports:
//   clk        in   1            rising-edge clock
//   rst_n      in   1            synchronous active-low reset
//   bus        slave modport of mem_access_unit_if (req_*, mem_*, rsp_*)
//   dbg_state  out  mau_state_t  current FSM state for observation
//
// Optional feature macro: MEM_BOUNDS_CHECK_EN
//   defined   - addresses >= MEM_DEPTH never write (wea stays 0) and loads
//               from them return data 0 with rsp_err=1.
//   undefined - no range check; rsp_err is constant 0.
// ----------------------------------------------------------------------------
module mem_access_unit
    import risc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    mem_access_unit_if.slave   bus,
    output mau_state_t         dbg_state
);

    mau_state_t        state_q;
    mau_state_t        state_d;

    logic              accept;
    logic              oor;        // current request is out of range
    logic              oor_q;      // captured with the request
    logic [RD_W-1:0]   rd_q;

    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_din_q;
    logic              mem_wea_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [RD_W-1:0]   rsp_rd_q;

    // req_ready folds in rst_n so nothing is accepted on a reset edge.
    assign bus.req_ready = (state_q == IDLE) & rst_n;
    assign accept        = bus.req_valid & bus.req_ready;

`ifdef MEM_BOUNDS_CHECK_EN
    logic in_range;

    mau_range_check u_range_check (
        .addr     (bus.req_addr),
        .in_range (in_range)
    );

    assign oor = ~in_range;
`else
    assign oor = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = bus.req_we ? ST_SETUP : LD_READ;
                end
            end
            ST_SETUP: state_d = ST_WRITE;
            ST_WRITE: state_d = IDLE;
            LD_READ:  state_d = LD_RESP;
            LD_RESP: begin
                // rsp_valid is always 1 in this state, so rsp_ready alone
                // completes the handshake.
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default:  state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Capture registers and registered outputs
    // ------------------------------------------------------------------
`ifdef MEM_BOUNDS_CHECK_EN
    logic rsp_err_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_wea_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_rd_q    <= '0;
            rd_q        <= '0;
            oor_q       <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    // addr/din only move here, so they are stable for the
                    // whole setup/write/release window of a store.
                    if (accept) begin
                        mem_addr_q <= bus.req_addr;
                        rd_q       <= bus.req_rd;
                        oor_q      <= oor;
                        if (bus.req_we) begin
                            mem_din_q <= bus.req_wdata;
                        end
                    end
                end
                ST_SETUP: begin
                    // Out-of-range stores still walk the states but never write.
                    mem_wea_q <= ~oor_q;
                end
                ST_WRITE: begin
                    mem_wea_q <= 1'b0;
                end
                LD_READ: begin
                    rsp_valid_q <= 1'b1;
                    rsp_rd_q    <= rd_q;
                    rsp_data_q  <= oor_q ? '0 : bus.mem_dout;
`ifdef MEM_BOUNDS_CHECK_EN
                    rsp_err_q   <= oor_q;
`endif
                end
                LD_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_din   = mem_din_q;
    assign bus.mem_wea   = mem_wea_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_rd    = rsp_rd_q;
`ifdef MEM_BOUNDS_CHECK_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif

    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// ----------------------------------------------------------------------------
// tb_mem_access_unit
// Self-checking bench for mem_access_unit with a behavioural 64x16
// level-sensitive data memory and a reference memory array.
// Honours MEM_BOUNDS_CHECK_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_mem_access_unit;
    import risc_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_unit_if bus ();
    mau_state_t        dbg_state;

    mem_access_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- behavioural data memory ----------------
    logic [15:0] mem [0:63];

    always @(bus.mem_wea or bus.mem_addr or bus.mem_din) begin
        if (bus.mem_wea && bus.mem_addr < 16'd64) mem[bus.mem_addr[5:0]] = bus.mem_din;
    end

    assign bus.mem_dout = (bus.mem_addr < 16'd64) ? mem[bus.mem_addr[5:0]] : 16'h0000;

    // ---------------- scoreboard state ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] ref_mem [0:63];
    logic [15:0] exp_q [$];
    logic        err_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_range(input int a);
        return a < 64;
    endfunction

    function automatic bit bounds_on();
`ifdef MEM_BOUNDS_CHECK_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- protocol monitors ----------------
    logic [15:0] prev_addr, prev_din;
    logic        prev_wea = 1'b0;
    logic        prev_rstn = 1'b0;
    int          wea_run = 0;

    always @(negedge clk) begin
        if (rst_n && prev_rstn && (prev_wea || bus.mem_wea)) begin
            check("addr_stable_around_wea", bus.mem_addr, prev_addr);
            check("din_stable_around_wea", bus.mem_din, prev_din);
        end
        if (bus.mem_wea) begin
            wea_run++;
        end else if (wea_run != 0) begin
            check("wea_width", wea_run, 1);
            wea_run = 0;
        end
        prev_addr = bus.mem_addr;
        prev_din  = bus.mem_din;
        prev_wea  = bus.mem_wea;
        prev_rstn = rst_n;
    end

    // ---------------- driver tasks ----------------
    // Presents a request and waits (bounded) for the accepting edge.
    // acc is the cycle in which valid & ready were both high.
    task automatic send(input logic we, input logic [15:0] addr, input logic [15:0] data,
                        input logic [2:0] rd, output int acc, output bit ok);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = data;
        bus.req_rd    = rd;
        ok  = 1'b0;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.req_ready) begin
                acc = cyc;
                ok  = 1'b1;
                tick();
                break;
            end
            tick();
        end
        bus.req_valid = 1'b0;
        bus.req_addr  = 16'($urandom);
        bus.req_wdata = 16'($urandom);
        bus.req_rd    = 3'($urandom);
        bus.req_we    = 1'($urandom);
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic do_store(input logic [15:0] addr, input logic [15:0] data, output int acc);
        bit ok;
        bit wr = !bounds_on() || in_range(int'(addr));
        send(1'b1, addr, data, 3'd0, acc, ok);
        if (!ok) return;
        check("st_setup_wea", bus.mem_wea, 0);
        check("st_setup_addr", bus.mem_addr, addr);
        check("st_setup_din", bus.mem_din, data);
        check("st_busy_ready", bus.req_ready, 0);
        tick();
        check("st_write_wea", bus.mem_wea, wr);
        check("st_write_addr", bus.mem_addr, addr);
        check("st_write_din", bus.mem_din, data);
        tick();
        check("st_release_wea", bus.mem_wea, 0);
        check("st_release_addr", bus.mem_addr, addr);
        check("st_release_ready", bus.req_ready, 1);
        if (wr && in_range(int'(addr))) ref_mem[addr[5:0]] = data;
    endtask

    task automatic do_load(input logic [15:0] addr, input logic [2:0] rd, input int hold);
        bit          ok;
        int          acc;
        int          n;
        logic [15:0] exp_d;
        logic        exp_e;
        if (in_range(int'(addr))) begin
            exp_q.push_back(ref_mem[addr[5:0]]);
            err_q.push_back(1'b0);
        end else begin
            exp_q.push_back(16'h0000);
            err_q.push_back(bounds_on());
        end
        bus.rsp_ready = (hold == 0);
        send(1'b0, addr, 16'($urandom), rd, acc, ok);
        exp_d = exp_q.pop_front();
        exp_e = err_q.pop_front();
        if (!ok) return;
        check("ld_read_no_valid", bus.rsp_valid, 0);
        n = 0;
        while (!bus.rsp_valid && n < 10) begin
            tick();
            n++;
        end
        if (!bus.rsp_valid) begin
            check("rsp_timeout", 0, 1);
            bus.rsp_ready = 1'b1;
            return;
        end
        check("ld_latency", cyc - acc, 2);
        check("ld_data", bus.rsp_data, exp_d);
        check("ld_rd", bus.rsp_rd, rd);
        check("ld_err", bus.rsp_err, exp_e);
        for (int i = 0; i < hold; i++) begin
            check("bp_valid", bus.rsp_valid, 1);
            check("bp_data", bus.rsp_data, exp_d);
            check("bp_rd", bus.rsp_rd, rd);
            check("bp_ready_low", bus.req_ready, 0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        check("rsp_valid_at_handshake", bus.rsp_valid, 1);
        tick();
        check("rsp_valid_drop", bus.rsp_valid, 0);
        check("rsp_data_held", bus.rsp_data, exp_d);
        check("idle_after_rsp", 32'(dbg_state), 32'(IDLE));
        check("ready_after_rsp", bus.req_ready, 1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int          acc;
        int          prev_acc;
        bit          ok;
        logic [15:0] a;
        logic [15:0] old9;

        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = 16'($urandom);
            mem[i]     = ref_mem[i];
        end
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_rd    = '0;
        bus.rsp_ready = 1'b1;

        // 1. reset
        rst_n = 1'b0;
        tick(); tick(); tick();
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_din", bus.mem_din, 0);
        check("rst_mem_wea", bus.mem_wea, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_rsp_rd", bus.rsp_rd, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", bus.req_ready, 1);

        // 2. store then load the same word
        do_store(16'd5, 16'hBEEF, acc);
        check("mem5_written", mem[5], 16'hBEEF);
        do_load(16'd5, 3'd3, 0);

        // 3. back-pressure for 4 cycles
        do_load(16'd5, 3'd6, 4);

        // 4. back-to-back stores then loads over the whole memory
        prev_acc = 0;
        for (int i = 0; i < 64; i++) begin
            do_store(16'(i), 16'(i) ^ 16'hA5A5, acc);
            if (i > 0) check("store_spacing", acc - prev_acc, 3);
            prev_acc = acc;
        end
        for (int i = 0; i < 64; i++) begin
            do_load(16'(i), 3'(i), 0);
        end

        // 5. reset while a store sits in ST_SETUP
        old9 = ref_mem[9];
        send(1'b1, 16'd9, 16'h1234, 3'd0, acc, ok);
        check("midrst_in_setup", 32'(dbg_state), 32'(ST_SETUP));
        rst_n = 1'b0;
        tick();
        check("midrst_wea", bus.mem_wea, 0);
        check("midrst_state", 32'(dbg_state), 32'(IDLE));
        check("midrst_ready", bus.req_ready, 0);
        rst_n = 1'b1;
        tick();
        tick();
        check("midrst_idle_after", 32'(dbg_state), 32'(IDLE));
        check("midrst_mem9", mem[9], old9);
        do_load(16'd9, 3'd1, 0);

        // 6. out-of-range accesses (only meaningful with the range check)
        if (bounds_on()) begin
            do_store(16'd64, 16'h5555, acc);
            do_load(16'd70, 3'd2, 0);
            do_load(16'd5, 3'd4, 1);
        end

        // randomized mix against the reference memory
        for (int i = 0; i < 60; i++) begin
            if (bounds_on()) a = 16'($urandom_range(0, 79));
            else             a = 16'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) do_store(a, 16'($urandom), acc);
            else                           do_load(a, 3'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
        end

        // final memory image must match the reference model
        for (int i = 0; i < 64; i++) begin
            check($sformatf("final_mem_%0d", i), mem[i], ref_mem[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
